// File: rtl/rail_axle_detector.sv
// rail_axle_detector
// Counts axles entering and leaving a track section using two bouncy
// wheel sensors, and raises rail_detect while a train is present or a
// fault is latched.
// Optional feature: define RAIL_WATCHDOG_EN to add a no-edge watchdog
// that raises fault after TIMEOUT quiet cycles in ARRIVING/OCCUPIED.
module rail_axle_detector #(
    parameter int DEBOUNCE   = 4,
    parameter int CNT_W      = 6,
    parameter int CLEAR_HOLD = 8,
    parameter int TIMEOUT    = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sens_in,
    input  logic             sens_out,
    input  logic             clr_fault,
    output logic             rail_detect,
    output logic [CNT_W-1:0] axle_count,
    output logic [1:0]       det_state,
    output logic             fault
);

    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int HOLD_W = $clog2(CLEAR_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ARRIVING = 2'b01,
        ST_OCCUPIED = 2'b10,
        ST_CLEARING = 2'b11
    } state_t;

    // Bit 0 is the approach sensor, bit 1 the exit sensor.
    logic [1:0]      raw_s;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      filt_q;
    logic [1:0]      filt_prev_q;
    logic [DB_W-1:0] dcnt_q [2];
    logic            in_edge_q;
    logic            out_edge_q;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              fault_q;
    logic              fault_d;
    logic              rail_q;
    logic              rail_d;
    logic              fault_set_s;
    logic              wd_fire_s;

    assign raw_s = {sens_out, sens_in};

    // Synchronize, debounce and edge-detect both sensors.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            filt_q      <= 2'b00;
            filt_prev_q <= 2'b00;
            in_edge_q   <= 1'b0;
            out_edge_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= raw_s;
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    // Any agreement restarts the stability count.
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DB_W'(DEBOUNCE - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    dcnt_q[i] <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + DB_W'(1);
                end
            end
            in_edge_q  <= filt_q[0] & ~filt_prev_q[0];
            out_edge_q <= filt_q[1] & ~filt_prev_q[1];
        end
    end

`ifdef RAIL_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;

    // Watchdog: count quiet cycles while a train is expected to move.
    always_comb begin
        wd_d      = '0;
        wd_fire_s = 1'b0;
        if (((state_q == ST_ARRIVING) || (state_q == ST_OCCUPIED)) &&
            !(in_edge_q || out_edge_q)) begin
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                wd_fire_s = 1'b1;
                wd_d      = '0;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end else begin
            wd_d = '0;
        end
    end

    // Watchdog timer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_fire_s = 1'b0;
`endif

    // Next-state logic for counter, occupancy FSM, hold timer and fault.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hold_d      = '0;
        fault_set_s = 1'b0;

        case ({in_edge_q, out_edge_q})
            2'b10: begin
                if (count_q == CNT_MAX) begin
                    fault_set_s = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            2'b01: begin
                if (count_q == '0) begin
                    fault_set_s = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: begin
                // No edge, or simultaneous entry and exit: net zero.
                count_d = count_q;
            end
        endcase

        case (state_q)
            ST_IDLE: begin
                if (in_edge_q) begin
                    state_d = ST_ARRIVING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARRIVING: begin
                if (out_edge_q) begin
                    state_d = (count_d == '0) ? ST_CLEARING : ST_OCCUPIED;
                end else begin
                    state_d = ST_ARRIVING;
                end
            end
            ST_OCCUPIED: begin
                if (count_d == '0) begin
                    state_d = ST_CLEARING;
                end else begin
                    state_d = ST_OCCUPIED;
                end
            end
            ST_CLEARING: begin
                if (in_edge_q) begin
                    state_d = ST_ARRIVING;
                end else if (hold_q == HOLD_W'(CLEAR_HOLD - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEARING;
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new fault outranks a clear request in the same cycle.
        if (fault_set_s || wd_fire_s) begin
            fault_d = 1'b1;
        end else if (clr_fault && (count_q == '0)) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end

        rail_d = (state_d != ST_IDLE) | fault_d;
    end

    // Occupancy state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hold_q  <= '0;
            fault_q <= 1'b0;
            rail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            fault_q <= fault_d;
            rail_q  <= rail_d;
        end
    end

    assign rail_detect = rail_q;
    assign axle_count  = count_q;
    assign det_state   = state_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_rail_axle_detector.sv
// Table-driven bench for rail_axle_detector (DEBOUNCE=4, CNT_W=6,
// CLEAR_HOLD=8, TIMEOUT=1000). Each record holds sensor levels for n
// cycles, then the outputs are compared on the following falling edge.
module tb_rail_axle_detector;

    typedef struct {
        logic       si;
        logic       so;
        logic       clr;
        int         n;
        logic       rail;
        logic [5:0] cnt;
        logic [1:0] st;
        logic       flt;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       sens_in;
    logic       sens_out;
    logic       clr_fault;
    logic       rail_detect;
    logic [5:0] axle_count;
    logic [1:0] det_state;
    logic       fault;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    rail_axle_detector #(
        .DEBOUNCE  (4),
        .CNT_W     (6),
        .CLEAR_HOLD(8),
        .TIMEOUT   (1000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sens_in    (sens_in),
        .sens_out   (sens_out),
        .clr_fault  (clr_fault),
        .rail_detect(rail_detect),
        .axle_count (axle_count),
        .det_state  (det_state),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic rail, input logic [5:0] cnt,
                             input logic [1:0] st, input logic flt);
        chk({tag, ".rail_detect"}, {31'd0, rail_detect}, {31'd0, rail});
        chk({tag, ".axle_count"},  {26'd0, axle_count},  {26'd0, cnt});
        chk({tag, ".det_state"},   {30'd0, det_state},   {30'd0, st});
        chk({tag, ".fault"},       {31'd0, fault},       {31'd0, flt});
    endtask

    // Drive levels at a falling edge, hold n rising edges, stop at next falling edge.
    task automatic step(input logic si, input logic so, input logic clr, input int n);
        sens_in   = si;
        sens_out  = so;
        clr_fault = clr;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic si, input logic so, input logic clr, input int n,
                       input logic rail, input logic [5:0] cnt, input logic [1:0] st,
                       input logic flt);
        vec_t v;
        v.si = si; v.so = so; v.clr = clr; v.n = n;
        v.rail = rail; v.cnt = cnt; v.st = st; v.flt = flt;
        vecs.push_back(v);
    endtask

    initial begin
        // Train: 4 axles in, 4 axles out. Edge E0 is the first sample of sens_in high.
        add(1'b1, 1'b0, 1'b0, 6,  1'b0, 6'd0, 2'b00, 1'b0); // after E5
        add(1'b1, 1'b0, 1'b0, 1,  1'b0, 6'd0, 2'b00, 1'b0); // after E6
        add(1'b1, 1'b0, 1'b0, 1,  1'b1, 6'd1, 2'b01, 1'b0); // after E7: detect
        add(1'b1, 1'b0, 1'b0, 2,  1'b1, 6'd1, 2'b01, 1'b0);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd1, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 10, 1'b1, 6'd2, 2'b01, 1'b0);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd2, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 10, 1'b1, 6'd3, 2'b01, 1'b0);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd3, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 10, 1'b1, 6'd4, 2'b01, 1'b0);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd4, 2'b01, 1'b0);
        add(1'b0, 1'b1, 1'b0, 10, 1'b1, 6'd3, 2'b10, 1'b0);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd3, 2'b10, 1'b0);
        add(1'b0, 1'b1, 1'b0, 10, 1'b1, 6'd2, 2'b10, 1'b0);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd2, 2'b10, 1'b0);
        add(1'b0, 1'b1, 1'b0, 10, 1'b1, 6'd1, 2'b10, 1'b0);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd1, 2'b10, 1'b0);
        add(1'b0, 1'b1, 1'b0, 7,  1'b1, 6'd1, 2'b10, 1'b0); // after E6 of last axle
        add(1'b0, 1'b1, 1'b0, 1,  1'b1, 6'd0, 2'b11, 1'b0); // after E7: CLEARING
        add(1'b0, 1'b1, 1'b0, 2,  1'b1, 6'd0, 2'b11, 1'b0);
        add(1'b0, 1'b0, 1'b0, 5,  1'b1, 6'd0, 2'b11, 1'b0); // 7 cycles in CLEARING
        add(1'b0, 1'b0, 1'b0, 1,  1'b0, 6'd0, 2'b00, 1'b0); // 8th cycle: IDLE
        // Glitch of 3 cycles must be filtered out.
        add(1'b0, 1'b0, 1'b0, 10, 1'b0, 6'd0, 2'b00, 1'b0);
        add(1'b1, 1'b0, 1'b0, 3,  1'b0, 6'd0, 2'b00, 1'b0);
        add(1'b0, 1'b0, 1'b0, 12, 1'b0, 6'd0, 2'b00, 1'b0);
        // Exit axle in IDLE: underflow fault, then clear.
        add(1'b0, 1'b1, 1'b0, 10, 1'b1, 6'd0, 2'b00, 1'b1);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd0, 2'b00, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1,  1'b0, 6'd0, 2'b00, 1'b0);
        add(1'b0, 1'b0, 1'b0, 5,  1'b0, 6'd0, 2'b00, 1'b0);
        // Fault again, then clr_fault ignored while an axle is inside.
        add(1'b0, 1'b1, 1'b0, 10, 1'b1, 6'd0, 2'b00, 1'b1);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd0, 2'b00, 1'b1);
        add(1'b1, 1'b0, 1'b0, 10, 1'b1, 6'd1, 2'b01, 1'b1);
        add(1'b0, 1'b0, 1'b1, 10, 1'b1, 6'd1, 2'b01, 1'b1);
        add(1'b0, 1'b1, 1'b0, 10, 1'b1, 6'd0, 2'b11, 1'b1);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd0, 2'b00, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1,  1'b0, 6'd0, 2'b00, 1'b0);
        // Count 2, then simultaneous entry and exit.
        add(1'b1, 1'b0, 1'b0, 10, 1'b1, 6'd1, 2'b01, 1'b0);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd1, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 10, 1'b1, 6'd2, 2'b01, 1'b0);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd2, 2'b01, 1'b0);
        add(1'b1, 1'b1, 1'b0, 10, 1'b1, 6'd2, 2'b10, 1'b0);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd2, 2'b10, 1'b0);
        // Third axle: count 3 in OCCUPIED, ready for mid-train reset.
        add(1'b1, 1'b0, 1'b0, 10, 1'b1, 6'd3, 2'b10, 1'b0);
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 6'd3, 2'b10, 1'b0);

        sens_in   = 1'b0;
        sens_out  = 1'b0;
        clr_fault = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", 1'b0, 6'd0, 2'b00, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].si, vecs[i].so, vecs[i].clr, vecs[i].n);
            check_all($sformatf("v%0d", i), vecs[i].rail, vecs[i].cnt, vecs[i].st, vecs[i].flt);
        end

        // Reset in the middle of a train overrides everything in one edge.
        sens_in = 1'b1;
        reset   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all("mid_reset", 1'b0, 6'd0, 2'b00, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 12);
        check_all("post_reset", 1'b0, 6'd0, 2'b00, 1'b0);

        // One axle inside and then silence.
        step(1'b1, 1'b0, 1'b0, 8);
        check_all("wd_entry", 1'b1, 6'd1, 2'b01, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2);
`ifdef RAIL_WATCHDOG_EN
        step(1'b0, 1'b0, 1'b0, 997);
        check_all("wd_before", 1'b1, 6'd1, 2'b01, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1);
        check_all("wd_fire", 1'b1, 6'd1, 2'b01, 1'b1);
`else
        step(1'b0, 1'b0, 1'b0, 2000);
        check_all("wd_off", 1'b1, 6'd1, 2'b01, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rail_axle_detector.md
RAIL_AXLE_DETECTOR -- requirements
Module: rail_axle_detector

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 4: consecutive stable cycles required to accept a sensor level change.
REQ-002 SHALL have parameter CNT_W, default 6: axle counter width.
REQ-003 SHALL have parameter CLEAR_HOLD, default 8: cycles held in CLEARING before returning to IDLE.
REQ-004 SHALL have parameter TIMEOUT, default 1000: watchdog limit in cycles.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port sens_in, input, 1: raw, asynchronous, bouncy approach-side axle sensor.
REQ-008 SHALL have port sens_out, input, 1: raw, asynchronous, bouncy exit-side axle sensor.
REQ-009 SHALL have port clr_fault, input, 1: request to clear the fault flag.
REQ-010 SHALL have port rail_detect, output, 1: train present; drives the crossing controller input of the same name.
REQ-011 SHALL have port axle_count, output, CNT_W: axles currently inside the section.
REQ-012 SHALL have port det_state, output, 2: current FSM state.
REQ-013 SHALL have port fault, output, 1: sticky fault flag.

Function
REQ-014 SHALL pass each sensor through a 2-flop synchronizer, then a debounce filter; the filtered level changes only after the synchronized level differs from it for DEBOUNCE consecutive cycles; any disagreement shorter than that restarts the count.
REQ-015 SHALL generate a one-cycle edge pulse (in_edge, out_edge) on each filtered 0->1 transition.
REQ-016 SHALL raise rail_detect exactly DEBOUNCE+3 cycles after the first rising clk edge that samples a stable sens_in high from IDLE.
REQ-017 SHALL update axle_count as follows: in_edge alone -> +1; out_edge alone -> -1; both in the same cycle -> unchanged.
REQ-018 SHALL handle count at 2^CNT_W-1 with in_edge by saturating the count and setting fault.
REQ-019 SHALL handle count 0 with out_edge alone by holding the count at 0 and setting fault.
REQ-020 SHALL encode FSM states as IDLE=00, ARRIVING=01, OCCUPIED=10, CLEARING=11, driven on det_state.
REQ-021 SHALL transition from IDLE on in_edge to ARRIVING.
REQ-022 SHALL transition from ARRIVING on out_edge to OCCUPIED, or to CLEARING if the count reaches 0.
REQ-023 SHALL transition from OCCUPIED to CLEARING when the count reaches 0.
REQ-024 SHALL, in CLEARING, count CLEAR_HOLD cycles then go to IDLE; an in_edge during CLEARING goes to ARRIVING and resets the hold counter.
REQ-025 SHALL drive rail_detect = (det_state != IDLE) | fault, registered.
REQ-026 SHALL keep fault set until clr_fault is sampled high while axle_count == 0; clr_fault is ignored otherwise.
REQ-027 SHALL give a set condition priority over clr_fault in the same cycle.

Reset
REQ-028 SHALL on reset clear all of the following on the next clk edge, overriding all other activity including mid-train: synchronizers, filters, debounce counters, hold counter, watchdog timer, axle_count=0, det_state=IDLE, fault=0, rail_detect=0.

Configuration
REQ-029 SHALL, with RAIL_WATCHDOG_EN defined, run a timer in ARRIVING and OCCUPIED that restarts on any in_edge or out_edge and sets fault on reaching TIMEOUT cycles without an edge.
REQ-030 SHALL, without RAIL_WATCHDOG_EN, omit the timer, ignore TIMEOUT, and set fault only per REQ-018/REQ-019.

Verification (DEBOUNCE=4, CNT_W=6, CLEAR_HOLD=8, TIMEOUT=1000)
REQ-031 SHALL cover: reset, then 4 sens_in pulses (10 cycles high, 10 low) followed by 4 sens_out pulses -> rail_detect=1 at 7 cycles after the first rise; axle_count 1,2,3,4,3,2,1,0; det_state 01->10->11, then 00 after 8 cycles; rail_detect=0.
REQ-032 SHALL cover: sens_in high for 3 cycles only -> no edge, axle_count=0, rail_detect stays 0.
REQ-033 SHALL cover: sens_out pulse in IDLE -> fault=1, rail_detect=1, count 0; then clr_fault -> fault=0, rail_detect=0.
REQ-034 SHALL cover: count=2, in_edge and out_edge in the same cycle -> count stays 2, no fault.
REQ-035 SHALL cover: count=1, no edges for 1000 cycles -> fault=1 with the macro defined; fault=0 after 2000 cycles without it.
REQ-036 SHALL cover: reset asserted at count=3 in OCCUPIED -> next cycle count=0, det_state=00, rail_detect=0, fault=0.
